// File: rtl/neuron_slot_sched_if.sv
// Signal bundle between the host configuration side and neuron_slot_sched.
// The scheduler takes the slave view; the host (or a bench) takes the master view.
interface neuron_slot_sched_if #(
  parameter int NN = 8
);
  logic        run;
  logic        cfg_req;
  logic [31:0] cfg_div;
  logic        cfg_ack;
  logic [NN:0] tap_a;
  logic [NN:0] tap_b;
  logic [NN:0] tap_c;
  logic        tick;
  logic [NN:0] neuron_idx;
  logic [1:0]  phase;
  logic        frame_start;
  logic        tap_strobe;
  logic [31:0] frame_cnt;
  logic        busy;

  modport master (
    output run, cfg_req, cfg_div, tap_a, tap_b, tap_c,
    input  cfg_ack, tick, neuron_idx, phase, frame_start, tap_strobe, frame_cnt, busy
  );

  modport slave (
    input  run, cfg_req, cfg_div, tap_a, tap_b, tap_c,
    output cfg_ack, tick, neuron_idx, phase, frame_start, tap_strobe, frame_cnt, busy
  );
endinterface

// File: rtl/neuron_slot_sched.sv
// Time-multiplex scheduler: divides rawclk into tick enables and walks the
// {neuron_idx, phase} slot counter, with divider reloads only at frame boundaries.
module neuron_slot_sched #(
  parameter int          NN      = 8,
  parameter logic [31:0] DIV_RST = 32'd0
) (
  input logic                rawclk,
  input logic                reset,
  neuron_slot_sched_if.slave bus
);
  localparam int SW = NN + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_active_div;
  logic [31:0]   r_div_cnt;
  logic [SW-1:0] r_slot;
  logic          r_cfg_block;
  logic          r_tick;
  logic          r_frame_start;
  logic          r_tap_strobe;
  logic          r_cfg_ack;
  logic [NN:0]   r_neuron_idx;
  logic [1:0]    r_phase;
  logic [31:0]   r_frame_cnt;

  logic w_stop;
  logic w_count;
  logic w_hit;
  logic w_last;
  logic w_first;
  logic w_tap_match;
  logic w_start;
  logic w_accept;

  // A draining frame that has wrapped back to slot 0 must not issue another tick.
  always_comb begin
    w_stop      = (r_state == DRAIN) && !bus.run && (r_slot == '0);
    w_count     = (r_state != IDLE) && !w_stop;
    w_hit       = w_count && (r_div_cnt == r_active_div);
    w_last      = (r_slot == '1);
    w_first     = (r_slot == '0);
    w_tap_match = (r_slot[SW-1:2] == bus.tap_a) ||
                  (r_slot[SW-1:2] == bus.tap_b) ||
                  (r_slot[SW-1:2] == bus.tap_c);
    w_start     = (r_state == IDLE) && bus.run;
    if (r_state == IDLE) begin
      w_accept = bus.cfg_req && !r_cfg_block;
    end else begin
      w_accept = bus.cfg_req && !r_cfg_block && w_hit && w_last;
    end
  end

  always_ff @(posedge rawclk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.run) w_state_nxt = RUN;
      RUN:     if (!bus.run) w_state_nxt = DRAIN;
      DRAIN: begin
        if (bus.run) begin
          w_state_nxt = RUN;
        end else if (r_slot == '0) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rawclk) begin
    if (reset) begin
      r_active_div  <= DIV_RST;
      r_div_cnt     <= '0;
      r_slot        <= '0;
      r_cfg_block   <= 1'b0;
      r_tick        <= 1'b0;
      r_frame_start <= 1'b0;
      r_tap_strobe  <= 1'b0;
      r_cfg_ack     <= 1'b0;
      r_neuron_idx  <= '0;
      r_phase       <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_tick        <= w_hit;
      r_frame_start <= w_hit && w_first;
      r_tap_strobe  <= w_hit && (r_slot[1:0] == 2'd0) && w_tap_match;
      r_cfg_ack     <= w_accept;

      // Re-arm the handshake only once the host has dropped its request.
      if (w_accept) begin
        r_active_div <= bus.cfg_div;
        r_cfg_block  <= 1'b1;
      end else if (!bus.cfg_req) begin
        r_cfg_block  <= 1'b0;
      end

      if (w_start) begin
        r_div_cnt <= '0;
        r_slot    <= '0;
      end else if (w_hit) begin
        r_div_cnt    <= '0;
        r_slot       <= r_slot + 1'b1;
        r_neuron_idx <= r_slot[SW-1:2];
        r_phase      <= r_slot[1:0];
        if (w_last) begin
          r_frame_cnt <= r_frame_cnt + 32'd1;
        end
      end else if (w_count) begin
        r_div_cnt <= r_div_cnt + 32'd1;
      end
    end
  end

  assign bus.tick        = r_tick;
  assign bus.neuron_idx  = r_neuron_idx;
  assign bus.phase       = r_phase;
  assign bus.frame_start = r_frame_start;
  assign bus.tap_strobe  = r_tap_strobe;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.cfg_ack     = r_cfg_ack;
  assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_neuron_slot_sched.sv
// Bench for neuron_slot_sched (NN=2, DIV_RST=3): directed scenarios plus randomized
// runs, with expected tick timing and slot values derived arithmetically.
module tb_neuron_slot_sched;
  localparam int NN    = 2;
  localparam int NSLOT = 4 << (NN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  neuron_slot_sched_if #(.NN(NN)) bus ();

  neuron_slot_sched #(.NN(NN), .DIV_RST(32'd3)) dut (
    .rawclk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nclk();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.cfg_req = 1'b0; bus.cfg_div = 32'd0;
    bus.tap_a = 3'd0; bus.tap_b = 3'd0; bus.tap_c = 3'd0;
    rst = 1'b1;
    nclk(); nclk();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      got = {bus.tick, bus.neuron_idx, bus.phase, bus.frame_start, bus.tap_strobe, bus.busy, bus.cfg_ack};
      checks++;
      if (got !== 10'd0 || bus.frame_cnt !== 32'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b cnt=%0d exp=0", cyc, got, bus.frame_cnt);
      end
      nclk();
    end
  endtask

  task automatic test_tick_period();
    logic exp_t;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      nclk();
      exp_t = (c > 1) && ((c - 1) % 4 == 0);
      checks++;
      if (bus.tick !== exp_t || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL period_tick cyc=%0d got tick=%0b busy=%0b exp tick=%0b busy=1", c, bus.tick, bus.busy, exp_t);
      end
      if (c == 5) begin
        checks++;
        if ({bus.neuron_idx, bus.phase, bus.frame_start} !== 6'b000_00_1) begin
          errors++;
          $display("FAIL first_tick idx=%0d ph=%0d fs=%0b exp idx=0 ph=0 fs=1", bus.neuron_idx, bus.phase, bus.frame_start);
        end
      end
    end
  endtask

  task automatic test_frame();
    int k;
    logic [8:0] got, exp;
    do_reset();
    bus.run = 1'b1; bus.cfg_req = 1'b1; bus.cfg_div = 32'd0;
    nclk();
    checks++;
    if ({bus.cfg_ack, bus.busy, bus.tick} !== 3'b110) begin
      errors++;
      $display("FAIL idle_load_run got ack/busy/tick=%b exp=110", {bus.cfg_ack, bus.busy, bus.tick});
    end
    bus.cfg_req = 1'b0;
    for (int n = 0; n < 2 * NSLOT; n++) begin
      nclk();
      k = n % NSLOT;
      exp = {1'b1, 3'(k / 4), 2'(k % 4), 1'(k == 0), 1'(k == 0), 1'b1};
      got = {bus.tick, bus.neuron_idx, bus.phase, bus.frame_start, bus.tap_strobe, bus.busy};
      checks++;
      if (got !== exp || bus.frame_cnt !== 32'((n + 1) / NSLOT)) begin
        errors++;
        $display("FAIL frame_seq n=%0d got=%b cnt=%0d exp=%b cnt=%0d", n, got, bus.frame_cnt, exp, (n + 1) / NSLOT);
      end
    end
  endtask

  task automatic test_tap();
    int n, strobes;
    logic is_t, exp_tap;
    do_reset();
    bus.tap_a = 3'd5;
    bus.run = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 131; c++) begin
      nclk();
      is_t = (c > 1) && ((c - 1) % 4 == 0);
      n = (c - 1) / 4 - 1;
      exp_tap = is_t && (n % 4 == 0) && ((n / 4 == 0) || (n / 4 == 5));
      if (bus.tap_strobe === 1'b1) strobes++;
      checks++;
      if (bus.tap_strobe !== exp_tap) begin
        errors++;
        $display("FAIL tap_strobe cyc=%0d got=%0b exp=%0b", c, bus.tap_strobe, exp_tap);
      end
    end
    checks++;
    if (strobes != 2) begin
      errors++;
      $display("FAIL tap_count got=%0d exp=2", strobes);
    end
  endtask

  task automatic test_cfg_boundary();
    logic exp_t, exp_a;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 197; c++) begin
      nclk();
      exp_a = (c == 129) || (c == 193);
      if (c <= 129)      exp_t = (c > 1) && ((c - 1) % 4 == 0);
      else if (c <= 193) exp_t = 1'b1;
      else               exp_t = ((c - 193) % 2 == 0);
      checks++;
      if ({bus.tick, bus.cfg_ack} !== {exp_t, exp_a}) begin
        errors++;
        $display("FAIL cfg_boundary cyc=%0d got tick/ack=%b exp=%b", c, {bus.tick, bus.cfg_ack}, {exp_t, exp_a});
      end
      if (c == 193) begin
        checks++;
        if (bus.frame_cnt !== 32'd3 || {bus.neuron_idx, bus.phase} !== 5'b111_11) begin
          errors++;
          $display("FAIL cfg_frames cnt=%0d idx=%0d ph=%0d exp cnt=3 idx=7 ph=3", bus.frame_cnt, bus.neuron_idx, bus.phase);
        end
      end
      if (c == 45) begin bus.cfg_req = 1'b1; bus.cfg_div = 32'd0; end
      if (c == 170) bus.cfg_req = 1'b0;
      if (c == 171) begin bus.cfg_req = 1'b1; bus.cfg_div = 32'd1; end
    end
    bus.cfg_req = 1'b0;
  endtask

  task automatic test_drain();
    int m, k;
    logic exp_t, exp_b;
    logic [6:0] got, exp;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      nclk();
      m = (c - 1) / 4;
      if (m > NSLOT) m = NSLOT;
      k = (m == 0) ? 0 : m - 1;
      exp_t = (c > 1) && ((c - 1) % 4 == 0) && (c <= 129);
      exp_b = (c <= 129);
      exp = {exp_t, 3'(k / 4), 2'(k % 4), exp_b};
      got = {bus.tick, bus.neuron_idx, bus.phase, bus.busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drain cyc=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 53) bus.run = 1'b0;
    end
    checks++;
    if (bus.frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL drain_frames got=%0d exp=1", bus.frame_cnt);
    end
  endtask

  task automatic test_drain_resume();
    int m, k;
    logic exp_t;
    logic [6:0] got, exp;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 175; c++) begin
      nclk();
      m = (c - 1) / 4;
      k = (m == 0) ? 0 : (m - 1) % NSLOT;
      exp_t = (c > 1) && ((c - 1) % 4 == 0);
      exp = {exp_t, 3'(k / 4), 2'(k % 4), 1'b1};
      got = {bus.tick, bus.neuron_idx, bus.phase, bus.busy};
      checks++;
      if (got !== exp || bus.frame_cnt !== 32'(m / NSLOT)) begin
        errors++;
        $display("FAIL drain_resume cyc=%0d got=%b cnt=%0d exp=%b cnt=%0d", c, got, bus.frame_cnt, exp, m / NSLOT);
      end
      if (c == 53) bus.run = 1'b0;
      if (c == 85) bus.run = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 149; c++) begin
      nclk();
      if (c == 140) begin bus.cfg_req = 1'b1; bus.cfg_div = 32'd0; end
    end
    checks++;
    if (bus.tick !== 1'b1 || bus.frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL pre_reset tick=%0b cnt=%0d exp tick=1 cnt=1", bus.tick, bus.frame_cnt);
    end
    rst = 1'b1;
    nclk();
    got = {bus.tick, bus.neuron_idx, bus.phase, bus.frame_start, bus.tap_strobe, bus.busy, bus.cfg_ack};
    checks++;
    if (got !== 10'd0 || bus.frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b cnt=%0d exp=0", got, bus.frame_cnt);
    end
    rst = 1'b0;
    bus.cfg_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      nclk();
      checks++;
      if ({bus.tick, bus.busy, bus.cfg_ack} !== {1'(c == 5), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL restart cyc=%0d got tick/busy/ack=%b exp=%b", c, {bus.tick, bus.busy, bus.cfg_ack}, {1'(c == 5), 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int d, nd, total, tl, m, k, ta, tb, tc;
      logic is_t, e_fs, e_tap, e_b;
      logic [9:0] got, exp;
      d  = int'($urandom_range(4, 0));
      nd = int'($urandom_range(61, 0));
      if (nd % NSLOT == NSLOT - 1) nd--;
      ta = int'($urandom_range(7, 0));
      tb = int'($urandom_range(7, 0));
      tc = int'($urandom_range(7, 0));
      total = NSLOT * (nd / NSLOT + 1);
      tl = 2 + total * (d + 1);
      do_reset();
      bus.tap_a = 3'(ta); bus.tap_b = 3'(tb); bus.tap_c = 3'(tc);
      bus.cfg_req = 1'b1; bus.cfg_div = 32'(d);
      nclk();
      checks++;
      if ({bus.cfg_ack, bus.busy} !== 2'b10) begin
        errors++;
        $display("FAIL rnd_load it=%0d got ack/busy=%b exp=10", it, {bus.cfg_ack, bus.busy});
      end
      bus.cfg_req = 1'b0;
      bus.run = 1'b1;
      for (int c = 2; c <= tl + 3; c++) begin
        nclk();
        m = (c - 2) / (d + 1);
        if (m > total) m = total;
        k = (m == 0) ? 0 : (m - 1) % NSLOT;
        is_t  = (c > 2) && ((c - 2) % (d + 1) == 0) && (c <= tl);
        e_fs  = is_t && (k == 0);
        e_tap = is_t && (k % 4 == 0) && ((k / 4 == ta) || (k / 4 == tb) || (k / 4 == tc));
        e_b   = (c <= tl);
        exp = {is_t, 3'(k / 4), 2'(k % 4), e_fs, e_tap, e_b, 1'b0};
        got = {bus.tick, bus.neuron_idx, bus.phase, bus.frame_start, bus.tap_strobe, bus.busy, bus.cfg_ack};
        checks++;
        if (got !== exp || bus.frame_cnt !== 32'(m / NSLOT)) begin
          errors++;
          $display("FAIL rnd it=%0d d=%0d cyc=%0d got=%b cnt=%0d exp=%b cnt=%0d", it, d, c, got, bus.frame_cnt, exp, m / NSLOT);
        end
        if (is_t && (m - 1 == nd)) bus.run = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_frame();
    test_tap();
    test_cfg_boundary();
    test_drain();
    test_drain_resume();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
